issue_decode: RTL and testbench
===============================

Name: issue_decode

Overview:
- Decode/issue stage directly upstream of the 32x32 register file.
- Holds one RV32I instruction from fetch, decodes it and drives register-file read addresses `ra`/`rb` from the held instruction.
- Tracks in-flight destination registers in a scoreboard and stalls issue on RAW/WAW hazards.
- Forwards the writeback port (`rd`/`we`/`di`) to the register file and passes a decoded bundle downstream to execute.

Parameters:
- XLEN, 32, data/instruction width.
- NREG, 32, architectural registers; scoreboard width; index width = 5.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch offers instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- flush  in  1  discard held instruction.
- ra  out  5  register-file port A address (rs1).
- rb  out  5  register-file port B address (rs2).
- wb_valid  in  1  writeback result present.
- wb_rd  in  5  writeback destination.
- wb_data  in  32  writeback value.
- rf_we  out  1  register-file write enable.
- rf_rd  out  5  register-file write address.
- rf_di  out  32  register-file write data.
- out_valid  out  1  decoded instruction issuing.
- out_ready  in  1  execute accepts.
- out_pc  out  32  held PC.
- out_imm  out  32  sign-extended immediate.
- out_opcode  out  7  instr[6:0].
- out_funct  out  4  {instr[30], instr[14:12]}.
- out_rd  out  5  destination; 0 if no write.
- out_illegal  out  1  opcode not in RV32I base set.

Behaviour:
- State:
  - `full` flag, instruction/pc registers, 32-bit `pend` scoreboard.
  - Two states: EMPTY (full=0), HELD (full=1).
- Reset: full=0, instr=0, pc=0, pend=0.
  - Hence out_valid=0, in_ready=1, ra=rb=0, out_rd=0, out_imm=0, out_illegal=0 (instr 0 treated as not illegal while empty; out_* qualified by out_valid).
- Register-file operand use by opcode:
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - uses_rs2: BRANCH, STORE, OP.
  - writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  - Illegal opcodes: no rs use, no rd write, out_illegal=1.
- `ra` = uses_rs1 ? instr[19:15] : 0; `rb` = uses_rs2 ? instr[24:20] : 0; combinational from held instruction. Register-file data is valid the same cycle.
- Immediate by opcode:
  - I-type (JALR/LOAD/OP-IMM): sign-extend instr[31:20].
  - S-type (STORE): {instr[31:25], instr[11:7]}.
  - B-type (BRANCH): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (LUI/AUIPC): {instr[31:12], 12'b0}.
  - J-type (JAL): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All others: 0.
- Hazard = full & ((ra!=0 & pend[ra]) | (rb!=0 & pend[rb]) | (out_rd!=0 & pend[out_rd])).
- out_valid = full & ~hazard & ~flush.
- Issue = out_valid & out_ready.
- in_ready = ~full | issue | flush.
- Load: in_valid & in_ready captures instr/pc and sets full=1; otherwise issue or flush clears full.
  - Back-to-back issue every cycle is possible with no bubble.
- Scoreboard, per bit, next-state:
  - pend[i] set if issue & out_rd==i & i!=0.
  - pend[i] cleared if wb_valid & wb_rd==i.
  - Set wins over clear on the same index. Bit 0 is always 0.
  - Clearing takes effect next cycle: a stalled dependent issues one cycle after its writeback.
- Writeback pass-through, combinational:
  - rf_we = wb_valid & wb_rd!=0.
  - rf_rd = wb_rd; rf_di = wb_data.
  - Writes to x0 are suppressed.
- flush:
  - Drops the held instruction (full=0 next cycle unless a new instruction loads the same cycle).
  - Suppresses issue; does not modify pend (in-flight writebacks still retire).
- wb_valid for a register whose pend bit is 0: write proceeds, pend unchanged.
- rst asserted mid-stall: all state returns to reset values next edge, overriding in_valid/wb/flush.

Optional Feature:
- Macro: ISSUE_DECODE_WB_BYPASS_EN.
- Defined: the hazard check uses pend & ~wbmask, where wbmask is the one-hot of wb_rd when wb_valid. A dependent instruction issues in the same cycle as its writeback (zero-cycle penalty). The register file is written that edge; execute must take the operand from wb_data via its own forwarding.
- Undefined: hazard uses registered pend only (one-cycle penalty as above).

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 → out_valid=0, in_ready=1, ra=rb=0, rf_we=0 throughout.
- Independent stream: addi x1,x0,5 then addi x2,x0,7, out_ready=1 → each issues one cycle after load; out_imm=5, then 7; pend=0x6 after both.
- RAW stall: addi x1,x0,5 issued, then add x3,x1,x2 → out_valid=0 and ra=1 held until wb_valid with wb_rd=1. Issues 1 cycle later (same cycle with ISSUE_DECODE_WB_BYPASS_EN); rf_we=1, rf_rd=1.
- x0 handling: wb_valid with wb_rd=0, wb_data=0xDEADBEEF → rf_we=0. addi x0,x0,1 issues with out_rd=0 and pend unchanged.
- Immediates: sw x5,-4(x6); beq x1,x2,-8; jal x1,+2048; lui x7,0x12345 → out_imm = 0xFFFFFFFC, 0xFFFFFFF8, 0x00000800, 0x12345000; rb=5 for sw.
- Flush during stall: stalled add on pending x1, assert flush with new in_valid → held instr dropped, new instr loaded next cycle, pend[1] still 1 until its writeback.

Source files
------------

// File: rtl/issue_decode.sv
// Decode/issue stage ahead of the 32x32 register file: holds one RV32I instruction, tracks pending
// destinations and stalls on RAW/WAW hazards. Optional macro ISSUE_DECODE_WB_BYPASS_EN removes the writeback penalty.
module issue_decode #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  input  logic            flush,
  output logic [4:0]      ra,
  output logic [4:0]      rb,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [31:0]     wb_data,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [31:0]     rf_di,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [31:0]     out_imm,
  output logic [6:0]      out_opcode,
  output logic [3:0]      out_funct,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {EMPTY, HELD} state_t;

  state_t             state, state_nxt;
  logic [XLEN-1:0]    instr_p0, pc_p0;
  logic [NREG-1:0]    pend, pend_nxt, pend_chk;
  logic [6:0]         opcode;
  logic               full, hazard, issue, load;
  logic               uses_rs1, uses_rs2, writes_rd, illegal;

  function automatic logic signed [31:0] imm_gen(input logic [31:0] i, input logic [6:0] opc);
    logic signed [31:0] imm;
    case (opc)
      OPC_JALR, OPC_LOAD, OPC_OPIMM: imm = {{20{i[31]}}, i[31:20]};
      OPC_STORE:                     imm = {{20{i[31]}}, i[31:25], i[11:7]};
      OPC_BRANCH:                    imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:            imm = {i[31:12], 12'b0};
      OPC_JAL:                       imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:                       imm = '0;
    endcase
    return imm;
  endfunction

  assign opcode = instr_p0[6:0];

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
  end

  assign full        = (state == HELD);
  assign ra          = uses_rs1 ? instr_p0[19:15] : 5'd0;
  assign rb          = uses_rs2 ? instr_p0[24:20] : 5'd0;
  assign out_rd      = writes_rd ? instr_p0[11:7] : 5'd0;
  assign out_imm     = imm_gen(instr_p0, opcode);
  assign out_opcode  = opcode;
  assign out_funct   = {instr_p0[30], instr_p0[14:12]};
  assign out_pc      = pc_p0;
  assign out_illegal = full & illegal;

  // A writeback retiring this cycle can optionally unblock its dependent immediately.
`ifdef ISSUE_DECODE_WB_BYPASS_EN
  logic [NREG-1:0] wbmask;
  assign wbmask   = wb_valid ? (NREG'(1) << wb_rd) : '0;
  assign pend_chk = pend & ~wbmask;
`else
  assign pend_chk = pend;
`endif

  assign hazard    = full & (((ra != 5'd0) & pend_chk[ra]) |
                             ((rb != 5'd0) & pend_chk[rb]) |
                             ((out_rd != 5'd0) & pend_chk[out_rd]));
  assign out_valid = full & ~hazard & ~flush;
  assign issue     = out_valid & out_ready;
  assign in_ready  = ~full | issue | flush;
  assign load      = in_valid & in_ready;

  assign rf_we = wb_valid & (wb_rd != 5'd0);
  assign rf_rd = wb_rd;
  assign rf_di = wb_data;

  always_comb begin
    state_nxt = state;
    if (load)
      state_nxt = HELD;
    else if (issue | flush)
      state_nxt = EMPTY;
  end

  // Set on issue beats clear on writeback for the same register.
  always_comb begin
    pend_nxt = pend;
    for (int i = 1; i < NREG; i++) begin
      if (wb_valid && wb_rd == 5'(i))
        pend_nxt[i] = 1'b0;
      if (issue && out_rd == 5'(i))
        pend_nxt[i] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  // Holding-register stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_p0 <= '0;
      pc_p0    <= '0;
    end else if (load) begin
      instr_p0 <= in_instr;
      pc_p0    <= in_pc;
    end
  end

endmodule

// File: tb/tb_issue_decode.sv
// Scoreboard bench for issue_decode: expected issues are queued as instructions are offered
// and popped when the stage issues; hazard, flush and writeback behaviour are checked directly.
module tb_issue_decode;

`ifdef ISSUE_DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, wb_valid, out_ready;
  logic [31:0] in_instr, in_pc, wb_data;
  logic [4:0]  wb_rd;
  logic        in_ready, rf_we, out_valid, out_illegal;
  logic [4:0]  ra, rb, rf_rd, out_rd;
  logic [31:0] rf_di, out_pc, out_imm;
  logic [6:0]  out_opcode;
  logic [3:0]  out_funct;

  int n_cmp = 0;
  int n_bad = 0;
  int n_iss = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        ill;
  } exp_t;
  exp_t q[$];

  issue_decode dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .ra(ra), .rb(rb), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .rf_we(rf_we), .rf_rd(rf_rd), .rf_di(rf_di), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm), .out_opcode(out_opcode),
    .out_funct(out_funct), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [4:0] ra_e, input logic [4:0] rb_e,
                       input logic ill, input bit push);
    exp_t e;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    if (push) begin
      e.pc = pc; e.imm = imm; e.rd = rd; e.ra = ra_e; e.rb = rb_e; e.ill = ill;
      q.push_back(e);
    end
    @(negedge clk);
    check("in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic writeback(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_rd    = r;
    wb_data  = d;
    @(negedge clk);
    check("rf_we", 32'(rf_we), 32'(r != 5'd0));
    check("rf_rd", 32'(rf_rd), 32'(r));
    check("rf_di", rf_di, d);
    tick();
    wb_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_iss++;
      if (q.size() == 0) begin
        check("unexpected_issue_pc", out_pc, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("issue_pc", out_pc, e.pc);
        check("issue_imm", out_imm, e.imm);
        check("issue_rd", 32'(out_rd), 32'(e.rd));
        check("issue_ra", 32'(ra), 32'(e.ra));
        check("issue_rb", 32'(rb), 32'(e.rb));
        check("issue_illegal", 32'(out_illegal), 32'(e.ill));
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h0;
    flush = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; out_ready = 1'b0;

    // reset with a pending offer
    repeat (2) begin
      tick();
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_ra", 32'(ra), 0);
      check("rst_rb", 32'(rb), 0);
      check("rst_rf_we", 32'(rf_we), 0);
      check("rst_illegal", 32'(out_illegal), 0);
      check("rst_imm", out_imm, 0);
    end
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // independent stream
    offer(32'h0050_0093, 32'h0, 32'd5, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1);
    offer(32'h0070_0113, 32'h4, 32'd7, 5'd2, 5'd0, 5'd0, 1'b0, 1'b1);
    tick();
    check("pend_indep", dut.pend, 32'h6);

    // RAW stall: add x3,x1,x2
    offer(32'h0020_81B3, 32'h8, 32'd0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b1);
    @(negedge clk);
    check("raw_stall_valid", 32'(out_valid), 0);
    check("raw_stall_ra", 32'(ra), 1);
    check("raw_stall_rb", 32'(rb), 2);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'd7;
    @(negedge clk);
    check("raw_wb2_valid", 32'(out_valid), 0);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("raw_x1_still_valid", 32'(out_valid), 0);
    check("raw_x1_still_ra", 32'(ra), 1);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    @(negedge clk);
    check("raw_wb1_rf_we", 32'(rf_we), 1);
    check("raw_wb1_rf_rd", 32'(rf_rd), 1);
    check("raw_wb1_valid", 32'(out_valid), 32'(BYP));
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("raw_after_wb_valid", 32'(out_valid), 32'(!BYP));
    tick();
    check("pend_raw", dut.pend, 32'h8);

    // x0 handling
    writeback(5'd3, 32'h33);
    writeback(5'd0, 32'hDEAD_BEEF);
    offer(32'h0010_0013, 32'hC, 32'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    tick();
    check("pend_x0", dut.pend, 32'h0);

    // immediate formats back to back, then an illegal opcode
    offer(32'hFE53_2E23, 32'h100, 32'hFFFF_FFFC, 5'd0, 5'd6, 5'd5, 1'b0, 1'b1);
    offer(32'hFE20_8CE3, 32'h104, 32'hFFFF_FFF8, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1);
    offer(32'h0010_00EF, 32'h108, 32'h0000_0800, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1);
    offer(32'h1234_53B7, 32'h10C, 32'h1234_5000, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1);
    offer(32'hFFFF_FFFF, 32'h110, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    tick();
    check("pend_imm", dut.pend, 32'h82);

    // flush a stalled add and load a replacement in the same cycle
    offer(32'h0020_81B3, 32'h1F0, 32'd0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_pre_valid", 32'(out_valid), 0);
    tick();
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0090_0213; in_pc = 32'h200;
    begin
      exp_t e;
      e.pc = 32'h200; e.imm = 32'd9; e.rd = 5'd4; e.ra = 5'd0; e.rb = 5'd0; e.ill = 1'b0;
      q.push_back(e);
    end
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 1);
    check("flush_out_valid", 32'(out_valid), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("pend_flush", dut.pend, 32'h92);

    // back-pressure from execute
    out_ready = 1'b0;
    offer(32'h0030_0293, 32'h204, 32'd3, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("pend_bp", dut.pend, 32'hB2);

    writeback(5'd1, 32'h1);
    writeback(5'd4, 32'h4);
    writeback(5'd5, 32'h5);
    writeback(5'd7, 32'h7);
    check("pend_drained", dut.pend, 32'h0);

    repeat (2) tick();
    check("queue_empty", 32'(q.size()), 0);
    check("issue_count", 32'(n_iss), 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
